// File: rtl/demux4to1_n_bit_pkg.sv
// Shared types for the registered 1-to-4 demultiplexer.
// Lane count, select type and lane mask type are shared by the decoder, the interface and the top.
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0]           sel_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/demux4to1_n_bit_if.sv
// Bundle of producer-side inputs and lane-side outputs of the demultiplexer.
// The master modport is the producer/consumer side; the slave modport is the demux itself.
interface demux4to1_n_bit_if
  import demux_pkg::*;
#(
  parameter int N = 8
);

  logic         en;
  logic [N-1:0] a;
  sel_t         s;
  logic [N-1:0] z0;
  logic [N-1:0] z1;
  logic [N-1:0] z2;
  logic [N-1:0] z3;
  lane_mask_t   zv;

  modport master (
    output en, a, s,
    input  z0, z1, z2, z3, zv
  );

  modport slave (
    input  en, a, s,
    output z0, z1, z2, z3, zv
  );

endinterface

// File: rtl/demux4to1_n_bit_decoder.sv
// Combinational 2-to-4 one-hot decoder turning a lane select into a lane mask.
// Every select value maps to exactly one set bit.
module decoder2to4
  import demux_pkg::*;
(
  input  sel_t       sel,
  output lane_mask_t mask
);

  always_comb begin
    mask = '0;
    case (sel)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0010;
      2'd2:    mask = 4'b0100;
      2'd3:    mask = 4'b1000;
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/demux4to1_n_bit.sv
// Registered 1-to-4 demultiplexer: routes a to the selected lane with a valid strobe, clears the rest.
// Reset has priority over enable; with enable low every output holds.
module demux4to1_n_bit
  import demux_pkg::*;
#(
  parameter int N = 8
)(
  input logic              clk,
  input logic              rst,
  demux4to1_n_bit_if.slave bus
);

  lane_mask_t   mask;
  logic [N-1:0] lane_data [NUM_LANES];

  decoder2to4 u_decoder (
    .sel  (bus.s),
    .mask (mask)
  );

  // Gating a with the mask yields a for the selected lane and zero for the others.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_data[i] = mask[i] ? bus.a : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.z0 <= '0;
      bus.z1 <= '0;
      bus.z2 <= '0;
      bus.z3 <= '0;
      bus.zv <= '0;
    end else if (bus.en) begin
      bus.z0 <= lane_data[0];
      bus.z1 <= lane_data[1];
      bus.z2 <= lane_data[2];
      bus.z3 <= lane_data[3];
      bus.zv <= mask;
    end
  end

endmodule

// File: tb/tb_demux4to1_n_bit.sv
// Self-checking bench: directed steps on an 8-bit build, then random traffic on a 16-bit build.
// A lane-array reference model updated per edge supplies every expected value.
module tb_demux4to1_n_bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]  model_z8  [4];
  logic [3:0]  model_zv8;
  logic [15:0] model_z16 [4];
  logic [3:0]  model_zv16;

  demux4to1_n_bit_if #(.N(8))  bus8  ();
  demux4to1_n_bit_if #(.N(16)) bus16 ();

  demux4to1_n_bit #(.N(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  demux4to1_n_bit #(.N(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_select_known(input logic e, input logic [1:0] sel);
    checks++;
    assert (!(e === 1'b1 && $isunknown(sel)))
    else begin
      errors++;
      $error("[TB] FAIL sel_known observed=%b expected=known", sel);
    end
  endtask

  // Lane k receives the word and a one-hot strobe; every other lane reads as zero.
  task automatic model8_edge(input logic r, input logic e, input logic [7:0] d, input logic [1:0] sel);
    if (r) begin
      for (int i = 0; i < 4; i++) model_z8[i] = '0;
      model_zv8 = '0;
    end else if (e) begin
      for (int i = 0; i < 4; i++) model_z8[i] = (i == int'(sel)) ? d : 8'h00;
      model_zv8 = 4'(1 << int'(sel));
    end
  endtask

  task automatic model16_edge(input logic r, input logic e, input logic [15:0] d, input logic [1:0] sel);
    if (r) begin
      for (int i = 0; i < 4; i++) model_z16[i] = '0;
      model_zv16 = '0;
    end else if (e) begin
      for (int i = 0; i < 4; i++) model_z16[i] = (i == int'(sel)) ? d : 16'h0000;
      model_zv16 = 4'(1 << int'(sel));
    end
  endtask

  task automatic apply_stimulus8(input string tag, input logic r, input logic e, input logic [7:0] d, input logic [1:0] sel);
    @(negedge clk);
    rst      = r;
    bus8.en  = e;
    bus8.a   = d;
    bus8.s   = sel;
    check_select_known(e, sel);
    @(posedge clk);
    model8_edge(r, e, d, sel);
    if (r) model16_edge(r, bus16.en, bus16.a, bus16.s);
    #1;
    check_output({tag, ".z0"}, {8'h00, bus8.z0}, {8'h00, model_z8[0]});
    check_output({tag, ".z1"}, {8'h00, bus8.z1}, {8'h00, model_z8[1]});
    check_output({tag, ".z2"}, {8'h00, bus8.z2}, {8'h00, model_z8[2]});
    check_output({tag, ".z3"}, {8'h00, bus8.z3}, {8'h00, model_z8[3]});
    check_output({tag, ".zv"}, {12'h000, bus8.zv}, {12'h000, model_zv8});
    check_output({tag, ".onehot"}, 16'($countones(bus8.zv) <= 1), 16'd1);
  endtask

  task automatic apply_stimulus16(input string tag, input logic r, input logic e, input logic [15:0] d, input logic [1:0] sel);
    @(negedge clk);
    rst      = r;
    bus16.en = e;
    bus16.a  = d;
    bus16.s  = sel;
    check_select_known(e, sel);
    @(posedge clk);
    model16_edge(r, e, d, sel);
    if (r) model8_edge(r, bus8.en, bus8.a, bus8.s);
    #1;
    check_output({tag, ".z0"}, bus16.z0, model_z16[0]);
    check_output({tag, ".z1"}, bus16.z1, model_z16[1]);
    check_output({tag, ".z2"}, bus16.z2, model_z16[2]);
    check_output({tag, ".z3"}, bus16.z3, model_z16[3]);
    check_output({tag, ".zv"}, {12'h000, bus16.zv}, {12'h000, model_zv16});
    check_output({tag, ".onehot"}, 16'($countones(bus16.zv) <= 1), 16'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus8.en  = 1'b0;
    bus8.a   = '0;
    bus8.s   = 2'd0;
    bus16.en = 1'b0;
    bus16.a  = '0;
    bus16.s  = 2'd0;
    $display("[TB] starting demux4to1_n_bit bench");

    apply_stimulus8("reset0", 1'b1, 1'b1, 8'hFF, 2'd0);
    apply_stimulus8("reset1", 1'b1, 1'b1, 8'hFF, 2'd2);

    apply_stimulus8("sweep_s0", 1'b0, 1'b1, 8'b11010101, 2'd0);
    apply_stimulus8("sweep_s1", 1'b0, 1'b1, 8'b11010101, 2'd1);
    apply_stimulus8("sweep_s2", 1'b0, 1'b1, 8'b11010101, 2'd2);
    apply_stimulus8("sweep_s3", 1'b0, 1'b1, 8'b11010101, 2'd3);

    apply_stimulus8("switch_aa", 1'b0, 1'b1, 8'b10101010, 2'd0);
    apply_stimulus8("switch_f0", 1'b0, 1'b1, 8'b11110000, 2'd1);

    apply_stimulus8("hold_cap", 1'b0, 1'b1, 8'h5A, 2'd2);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus8($sformatf("hold%0d", i), 1'b0, 1'b0, 8'h33, 2'd3);
    end

    apply_stimulus8("rst_prio", 1'b1, 1'b1, 8'hC3, 2'd3);
    apply_stimulus8("rst_release", 1'b0, 1'b1, 8'hC3, 2'd3);

    bus8.en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      apply_stimulus16($sformatf("rand%0d", i),
                       ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 3) != 0),
                       16'($urandom),
                       2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
